// File: rtl/yrv_irq_pkg.sv
// rtl/yrv_irq_pkg.sv - shared types, defaults and arbitration search for the YRV interrupt controller
package yrv_irq_pkg;

    localparam int YRV_IRQ_NSRC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // First set bit of vec[n-1:0] scanning upward from start and wrapping; 0 if none set.
    function automatic int find_first(input logic [31:0] vec, input int n, input int start);
        int idx;
        find_first = 0;
        for (int k = 31; k >= 0; k--) begin
            if (k < n) begin
                idx = (start + k) % n;
                if (vec[idx[4:0]]) begin
                    find_first = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/yrv_irq_sync.sv
// rtl/yrv_irq_sync.sv - two-flop synchronizer with rising-edge detect for one asynchronous input
module yrv_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise
);

    logic meta;
    logic s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= d;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/yrv_irq_ctrl.sv
// rtl/yrv_irq_ctrl.sv - shares ei_req among NSRC sources and conditions the NMI input
// Define YRV_IRQ_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module yrv_irq_ctrl
    import yrv_irq_pkg::*;
#(
    parameter int NSRC = YRV_IRQ_NSRC_DEF,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_in,
    input  logic [NSRC-1:0] cfg_edge,
    input  logic [NSRC-1:0] cfg_en,
    input  logic            irq_ack,
    input  logic            irq_eoi,
    input  logic            nmi_src,
    output logic            ei_req,
    output logic            irq_valid,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pend,
    output logic            nmi_req
);

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] cand;
    logic            nmi_rise;
    logic            nmi_s_unused;
    logic            nmi_stage;
    logic [IDW-1:0]  win_id;
    logic            grant;
    int              start;
    irq_state_e      state_q;
    irq_state_e      state_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        yrv_irq_sync u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (src_in[i]),
            .s    (s[i]),
            .rise (rise[i])
        );
    end

    yrv_irq_sync u_nmi_sync (
        .clk  (clk),
        .reset(reset),
        .d    (nmi_src),
        .s    (nmi_s_unused),
        .rise (nmi_rise)
    );

    assign cand = pend & cfg_en;

`ifdef YRV_IRQ_RR_EN
    logic [IDW-1:0] last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= '0;
        end else if (grant) begin
            last_grant <= win_id;
        end
    end

    assign start = (int'(last_grant) + 1) % NSRC;
`else
    assign start = 0;
`endif

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|cand) state_d = REQ;
            end
            REQ: begin
                // The latched winner is kept; losing its candidacy withdraws the request.
                if (!cand[win_id]) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    state_d = SERVICE;
                    grant   = 1'b1;
                end
            end
            SERVICE: begin
                if (irq_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            win_id    <= '0;
            irq_id    <= '0;
            ei_req    <= 1'b0;
            irq_valid <= 1'b0;
            pend      <= '0;
            nmi_stage <= 1'b0;
            nmi_req   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ei_req    <= (state_d == REQ);
            irq_valid <= (state_d == SERVICE);
            if (state_q == IDLE && (|cand)) begin
                win_id <= IDW'(find_first(32'(cand), NSRC, start));
            end
            if (grant) begin
                irq_id <= win_id;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (cfg_edge[i]) begin
                    if (rise[i]) begin
                        pend[i] <= 1'b1;
                    end else if (grant && win_id == IDW'(i)) begin
                        pend[i] <= 1'b0;
                    end
                end else begin
                    pend[i] <= s[i];
                end
            end
            nmi_stage <= nmi_rise;
            nmi_req   <= nmi_stage;
        end
    end

endmodule

// File: tb/tb_yrv_irq_ctrl.sv
// tb/tb_yrv_irq_ctrl.sv - directed bench with a per-cycle reference model of yrv_irq_ctrl
module tb_yrv_irq_ctrl;

    localparam int NSRC = 8;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] src_in;
    logic [NSRC-1:0] cfg_edge;
    logic [NSRC-1:0] cfg_en;
    logic            irq_ack;
    logic            irq_eoi;
    logic            nmi_src;
    logic            ei_req;
    logic            irq_valid;
    logic [2:0]      irq_id;
    logic [NSRC-1:0] pend;
    logic            nmi_req;

    int n_cmp  = 0;
    int n_fail = 0;

    yrv_irq_ctrl #(.NSRC(NSRC)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_in   (src_in),
        .cfg_edge (cfg_edge),
        .cfg_en   (cfg_en),
        .irq_ack  (irq_ack),
        .irq_eoi  (irq_eoi),
        .nmi_src  (nmi_src),
        .ei_req   (ei_req),
        .irq_valid(irq_valid),
        .irq_id   (irq_id),
        .pend     (pend),
        .nmi_req  (nmi_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: input sample history plus the controller's observable state.
    logic [NSRC-1:0] h1 = '0, h2 = '0, h3 = '0;
    logic            n1 = 0, n2 = 0, n3 = 0, n4 = 0;
    logic [NSRC-1:0] m_pend = '0;
    logic            m_req = 0, m_valid = 0, m_nmi = 0;
    int              m_state = 0, m_win = 0, m_id = 0, m_last = 0;
    bit              started = 0;
`ifdef YRV_IRQ_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always @(posedge clk) begin
        logic [NSRC-1:0] cand;
        logic [NSRC-1:0] np;
        logic            g;
        bit              found;
        int              ns, st, idx;
        if (reset) begin
            h1 = '0; h2 = '0; h3 = '0;
            n1 = 0; n2 = 0; n3 = 0; n4 = 0;
            m_pend = '0; m_req = 0; m_valid = 0; m_nmi = 0;
            m_state = 0; m_win = 0; m_id = 0; m_last = 0;
            started = 1;
        end else begin
            cand = m_pend & cfg_en;
            g = (m_state == 1) && cand[m_win] && irq_ack;
            for (int i = 0; i < NSRC; i++) begin
                if (cfg_edge[i])
                    np[i] = (h2[i] & ~h3[i]) | (m_pend[i] & !(g && m_win == i));
                else
                    np[i] = h2[i];
            end
            ns = m_state;
            case (m_state)
                0: if (cand != 0) begin
                    ns = 1;
                    st = RR ? (m_last + 1) % NSRC : 0;
                    found = 0;
                    for (int k = 0; k < NSRC; k++) begin
                        idx = (st + k) % NSRC;
                        if (!found && cand[idx]) begin
                            m_win = idx;
                            found = 1;
                        end
                    end
                end
                1: if (!cand[m_win]) ns = 0;
                   else if (irq_ack) begin
                       ns = 2; m_id = m_win; m_last = m_win;
                   end
                default: if (irq_eoi) ns = 0;
            endcase
            m_nmi = n3 & ~n4;
            h3 = h2; h2 = h1; h1 = src_in;
            n4 = n3; n3 = n2; n2 = n1; n1 = nmi_src;
            m_pend = np;
            m_state = ns;
            m_req = (ns == 1);
            m_valid = (ns == 2);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ei_req", 32'(ei_req), 32'(m_req));
            chk("irq_valid", 32'(irq_valid), 32'(m_valid));
            if (m_valid) chk("irq_id", 32'(irq_id), m_id);
            chk("pend", 32'(pend), 32'(m_pend));
            chk("nmi_req", 32'(nmi_req), 32'(m_nmi));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ei(input string name);
        int k = 0;
        while (ei_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(ei_req), 32'd1);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        irq_eoi = 1'b1; tick(1); irq_eoi = 1'b0;
    endtask

    int exp5 [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef YRV_IRQ_RR_EN
        exp5 = '{1, 0, 1, 0};
`else
        exp5 = '{0, 0, 0, 0};
`endif
        reset = 1'b1; src_in = '0; cfg_edge = '0; cfg_en = '0;
        irq_ack = 1'b0; irq_eoi = 1'b0; nmi_src = 1'b0;
        tick(2);
        reset = 1'b0; cfg_edge = 8'hFF; cfg_en = 8'hFF;
        tick(1);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ei", 32'(ei_req), 32'h0);
        chk("rst_valid", 32'(irq_valid), 32'h0);

        // 1: edge handoff latency
        src_in = 8'h08;
        tick(3);
        chk("t1_pend_edge2", 32'(pend), 32'h08);
        chk("t1_ei_edge2", 32'(ei_req), 32'h0);
        tick(1);
        chk("t1_ei_edge3", 32'(ei_req), 32'h1);
        do_ack();
        chk("t1_id", 32'(irq_id), 32'd3);
        chk("t1_valid", 32'(irq_valid), 32'h1);
        chk("t1_pend_clr", 32'(pend), 32'h0);
        chk("t1_ei_low", 32'(ei_req), 32'h0);
        tick(2);
        do_eoi();
        chk("t1_eoi", 32'(irq_valid), 32'h0);
        src_in = '0;
        tick(3);

        // 2: fixed priority on simultaneous edges
        src_in = 8'h24;
        wait_ei("t2_req1");
        do_ack();
        chk("t2_id1", 32'(irq_id), 32'd2);
        do_eoi();
        wait_ei("t2_req2");
        do_ack();
        chk("t2_id2", 32'(irq_id), 32'd5);
        chk("t2_pend", 32'(pend), 32'h0);
        do_eoi();
        src_in = '0;
        tick(4);

        // 3: level source withdrawn without ack
        cfg_edge = 8'hFD;
        src_in = 8'h02;
        tick(4);
        src_in = '0;
        chk("t3_ei_up", 32'(ei_req), 32'h1);
        tick(3);
        chk("t3_ei_hold", 32'(ei_req), 32'h1);
        tick(1);
        chk("t3_ei_down", 32'(ei_req), 32'h0);
        tick(2);
        cfg_edge = 8'hFF;

        // 4: masked source stays pending
        cfg_en = 8'hEF;
        src_in = 8'h10;
        tick(3);
        chk("t4_pend", 32'(pend), 32'h10);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t4_masked", 32'(ei_req), 32'h0);
        end
        cfg_en = 8'hFF;
        tick(2);
        chk("t4_unmask", 32'(ei_req), 32'h1);
        do_ack();
        chk("t4_id", 32'(irq_id), 32'd4);
        do_eoi();
        src_in = '0;
        tick(3);

        // 5: arbitration order with two level sources held
        reset = 1'b1; tick(1); reset = 1'b0;
        cfg_edge = 8'hFC;
        src_in = 8'h03;
        for (int g = 0; g < 4; g++) begin
            wait_ei("t5_req");
            do_ack();
            chk("t5_id", 32'(irq_id), exp5[g]);
            tick(1);
            do_eoi();
        end
        src_in = '0;
        tick(6);
        cfg_edge = 8'hFF;

        // 6: reset mid-service, then NMI pulse
        src_in = 8'h08;
        wait_ei("t6_req");
        do_ack();
        src_in = 8'h48;
        tick(3);
        chk("t6_in_service", 32'(irq_valid), 32'h1);
        chk("t6_pend6", 32'(pend), 32'h40);
        reset = 1'b1; src_in = '0;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_ei", 32'(ei_req), 32'h0);
        chk("t6_rst_valid", 32'(irq_valid), 32'h0);
        chk("t6_rst_pend", 32'(pend), 32'h0);
        chk("t6_rst_nmi", 32'(nmi_req), 32'h0);
        nmi_src = 1'b1;
        tick(3);
        chk("t6_nmi_early", 32'(nmi_req), 32'h0);
        tick(1);
        chk("t6_nmi_pulse", 32'(nmi_req), 32'h1);
        tick(1);
        chk("t6_nmi_single", 32'(nmi_req), 32'h0);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
